// File: rtl/hazard_ctrl_unit_if.sv
// Hazard-unit signal bundle: pipeline-side hazard inputs and stall/flush/forward controls.
// Optional HAZARD_PERF_EN adds the stall/flush performance counter outputs.
interface hazard_ctrl_unit_if #(
    parameter int unsigned AW    = 5,
    parameter int unsigned CNT_W = 32
);
    logic [AW-1:0] rs1D;
    logic [AW-1:0] rs2D;
    logic [AW-1:0] rs1E;
    logic [AW-1:0] rs2E;
    logic [AW-1:0] rdE;
    logic [AW-1:0] rdM;
    logic [AW-1:0] rdW;
    logic          regwriteM;
    logic          regwriteW;
    logic          loadE;
    logic          pcsrcE;
    logic          mdu_startE;
    logic          mdu_done;
    logic [1:0]    forwardAE;
    logic [1:0]    forwardBE;
    logic          stallF;
    logic          stallD;
    logic          stallE;
    logic          flushD;
    logic          flushE;
    logic          flushM;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    // Pipeline side: drives hazard information, receives controls.
    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, regwriteM, regwriteW,
        output loadE, pcsrcE, mdu_startE, mdu_done,
`ifdef HAZARD_PERF_EN
        input  stall_cnt, flush_cnt,
`endif
        input  forwardAE, forwardBE, stallF, stallD, stallE, flushD, flushE, flushM
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, regwriteM, regwriteW,
        input  loadE, pcsrcE, mdu_startE, mdu_done,
`ifdef HAZARD_PERF_EN
        output stall_cnt, flush_cnt,
`endif
        output forwardAE, forwardBE, stallF, stallD, stallE, flushD, flushE, flushM
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: E-stage forwarding, load-use bubbles, branch flush, MDU wait.
// Define HAZARD_PERF_EN to add stall/flush performance counters.
module hazard_ctrl_unit #(
    parameter int unsigned AW          = 5,
    parameter int unsigned LOAD_STALLS = 1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    hazard_ctrl_unit_if.slave hz
);
    localparam logic [AW-1:0] RegZero = '0;
    localparam int unsigned   LdInit  = (LOAD_STALLS > 1) ? (LOAD_STALLS - 2) : 0;

    typedef enum logic [1:0] {StRun, StLdStall, StMduWait} state_e;

    state_e     state_q, state_d;
    logic [1:0] ld_cnt_q, ld_cnt_d;

    logic [1:0] fwd_a, fwd_b;
    logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
    logic       lu_hit;

    // M-stage result is younger than W, so it wins when both match.
    always_comb begin
        fwd_a = 2'b00;
        if (hz.regwriteM && hz.rdM != RegZero && hz.rdM == hz.rs1E) begin
            fwd_a = 2'b10;
        end else if (hz.regwriteW && hz.rdW != RegZero && hz.rdW == hz.rs1E) begin
            fwd_a = 2'b01;
        end
    end

    always_comb begin
        fwd_b = 2'b00;
        if (hz.regwriteM && hz.rdM != RegZero && hz.rdM == hz.rs2E) begin
            fwd_b = 2'b10;
        end else if (hz.regwriteW && hz.rdW != RegZero && hz.rdW == hz.rs2E) begin
            fwd_b = 2'b01;
        end
    end

    assign lu_hit = hz.loadE && (hz.rdE != RegZero) &&
                    ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_m  = 1'b0;
        unique case (state_q)
            StRun: begin
                if (hz.mdu_startE) begin
                    // A result ready in the issue cycle needs no freeze at all.
                    if (!hz.mdu_done) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        flush_m = 1'b1;
                        state_d = StMduWait;
                    end
                end else if (hz.pcsrcE) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (lu_hit) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                    if (LOAD_STALLS > 1) begin
                        state_d  = StLdStall;
                        ld_cnt_d = 2'(LdInit);
                    end
                end
            end
            StLdStall: begin
                if (hz.pcsrcE) begin
                    // The stalled consumer is on the wrong path; drop the stall.
                    flush_d  = 1'b1;
                    flush_e  = 1'b1;
                    state_d  = StRun;
                    ld_cnt_d = 2'd0;
                end else begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                    if (ld_cnt_q == 2'd0) begin
                        state_d = StRun;
                    end else begin
                        ld_cnt_d = ld_cnt_q - 2'd1;
                    end
                end
            end
            StMduWait: begin
                if (hz.mdu_done) begin
                    state_d = StRun;
                end else begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_m = 1'b1;
                end
            end
            default: begin
                state_d  = StRun;
                ld_cnt_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StRun;
            ld_cnt_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
        end
    end

    // Outputs are forced low combinationally for the whole time reset is held.
    assign hz.forwardAE = rst ? fwd_a : 2'b00;
    assign hz.forwardBE = rst ? fwd_b : 2'b00;
    assign hz.stallF    = rst & stall_f;
    assign hz.stallD    = rst & stall_d;
    assign hz.stallE    = rst & stall_e;
    assign hz.flushD    = rst & flush_d;
    assign hz.flushE    = rst & flush_e;
    assign hz.flushM    = rst & flush_m;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_f) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_d) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`endif
endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 SHALL have parameter AW, default 5, register-address width.
REQ-002 SHALL have parameter LOAD_STALLS, default 1, legal 1..4, bubble cycles per load-use hazard.
REQ-003 SHALL have parameter CNT_W, default 32, performance-counter width.
REQ-004 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have ports: rst  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: rs1D, rs2D  in  AW  decode-stage sources; rs1E, rs2E  in  AW  execute-stage sources.
REQ-007 SHALL have ports: rdE, rdM, rdW  in  AW  destinations; regwriteM, regwriteW  in  1  write enables.
REQ-008 SHALL have ports: loadE  in  1  E-stage instruction is a load; pcsrcE  in  1  taken branch/jump in E.
REQ-009 SHALL have ports: mdu_startE  in  1  multi-cycle op issued in E; mdu_done  in  1  multi-cycle result ready.
REQ-010 SHALL have ports: forwardAE, forwardBE  out  2  (00 regfile, 10 from M, 01 from W).
REQ-011 SHALL have ports: stallF, stallD, stallE, flushD, flushE, flushM  out  1  pipeline controls.

Function
REQ-012 forwardXE SHALL be 10 if regwriteM & rdM!=0 & rdM==rsXE, else 01 if regwriteW & rdW!=0 & rdW==rsXE, else 00; combinational, M over W.
REQ-013 FSM states SHALL be RUN, LD_STALL, MDU_WAIT; 2-bit down-counter ld_cnt used in LD_STALL.
REQ-014 Load-use hit SHALL be loadE & rdE!=0 & (rdE==rs1D | rdE==rs2D).
REQ-015 In RUN, precedence SHALL be mdu_startE > pcsrcE > load-use hit; lower events are ignored that cycle.
REQ-016 RUN + load-use: stallF=stallD=flushE=1 same cycle; if LOAD_STALLS>1 next state LD_STALL, ld_cnt=LOAD_STALLS-2, else stay RUN.
REQ-017 LD_STALL: stallF=stallD=flushE=1; ld_cnt==0 -> RUN, else decrement; total bubble cycles exactly LOAD_STALLS.
REQ-018 LD_STALL + pcsrcE=1: flushD=flushE=1, stalls deasserted, next state RUN (branch cancels stall).
REQ-019 RUN + pcsrcE: flushD=flushE=1 for that cycle only, state unchanged.
REQ-020 RUN + mdu_startE: stallF=stallD=stallE=flushM=1 that cycle; next state MDU_WAIT unless mdu_done same cycle (then RUN, no stall).
REQ-021 MDU_WAIT: stallF=stallD=stallE=flushM=1 while mdu_done=0; mdu_done=1 -> all deasserted that cycle, next state RUN.
REQ-022 All control outputs SHALL be 0 in any cycle not covered above; forwarding active in every state.

Reset
REQ-023 rst=0 SHALL asynchronously force state RUN, ld_cnt 0, counters 0, and all outputs 0 (forwarding included) while held.
REQ-024 Reset asserted mid-stall or mid-MDU_WAIT SHALL abandon it; first cycle after release SHALL be RUN.

Configuration
REQ-025 Macro HAZARD_PERF_EN defined: add outputs stall_cnt, flush_cnt (CNT_W each); stall_cnt increments each cycle stallF=1, flush_cnt each cycle flushD=1; both wrap to 0 past all-ones.
REQ-026 Macro HAZARD_PERF_EN undefined: those ports and registers SHALL not exist; all other behaviour identical.

Verification
REQ-027 rdM=rdW=rs1E=3, regwriteM=regwriteW=1 -> forwardAE=10; regwriteM=0 -> 01; rdM=rdW=0 -> 00.
REQ-028 LOAD_STALLS=3, loadE=1, rdE=5, rs2D=5 -> stallF/stallD/flushE high exactly 3 cycles, then RUN.
REQ-029 LOAD_STALLS=3, pcsrcE=1 on 2nd stall cycle -> flushD=flushE=1, stalls drop that cycle, total stall 1 cycle.
REQ-030 mdu_startE=1, mdu_done after 4 cycles -> stallE/flushM high 4 cycles, low on mdu_done cycle; mdu_startE with mdu_done same cycle -> no stall.
REQ-031 rst=0 during MDU_WAIT -> outputs 0 immediately, RUN after release; with HAZARD_PERF_EN, CNT_W=4, 17 stall cycles -> stall_cnt=1.
